// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus bundle shared by the OAM DMA arbiter and its environment.
interface oam_dma_arbiter_if;
    logic [15:0] cpu_addr;
    logic        cpu_wen;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_busy;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_wen, cpu_wdata, mem_rdata,
        output cpu_rdy, mem_addr, mem_wen, mem_wdata, dma_busy, dma_done
    );

    modport slave (
        output cpu_addr, cpu_wen, cpu_wdata, mem_rdata,
        input  cpu_rdy, mem_addr, mem_wen, mem_wdata, dma_busy, dma_done
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Shares the memory bus between the CPU and a sprite DMA engine that copies one
// source page to the OAM data register with alternating get/put cycles.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004,
    parameter int unsigned XFER_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    oam_dma_arbiter_if.master     bus
);

    localparam int unsigned IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       page_q, page_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             parity_q;
    logic             done_q, done_d;

    // State register; parity free-runs so reads land on get cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            idx_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            parity_q <= ~parity_q;
            done_q   <= done_d;
        end
    end

    // Next state and bus steering.
    always_comb begin
        state_d       = state_q;
        page_d        = page_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        bus.cpu_rdy   = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = bus.cpu_wdata;

        unique case (state_q)
            S_IDLE: begin
                bus.cpu_rdy = 1'b1;
                bus.mem_wen = bus.cpu_wen;
                if (bus.cpu_wen && (bus.cpu_addr == DMA_REG)) begin
                    page_d  = bus.cpu_wdata;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Parity 1 now means the next cycle is a get cycle.
                state_d = parity_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                bus.mem_addr  = {page_q, idx_q};
                bus.mem_wdata = 8'h00;
                state_d       = S_WRITE;
            end
            S_WRITE: begin
                bus.mem_addr  = OAM_DATA;
                bus.mem_wen   = 1'b1;
                bus.mem_wdata = bus.mem_rdata;
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dma_busy = (state_q != S_IDLE);
    assign bus.dma_done = done_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench: a full-page DMA instance and a single-byte DMA instance on a shared memory model.
module tb_oam_dma_arbiter;

    logic clk;
    logic rst_n;

    oam_dma_arbiter_if ifa ();
    oam_dma_arbiter_if ifb ();

    oam_dma_arbiter #(.XFER_LEN(256)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    oam_dma_arbiter #(.XFER_LEN(1))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    // Read data valid the cycle after the address.
    always @(posedge clk) begin
        ifa.mem_rdata <= mem[ifa.mem_addr];
        ifb.mem_rdata <= mem[ifb.mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int since_rst = 0;

    int a_rdy_low, a_done_cnt, a_wr_cnt, a_rd_cnt, a_bad_rd, a_rd_odd;
    logic [7:0] a_page;
    logic [7:0] a_log [0:255];
    int b_rdy_low, b_done_cnt, b_wr_cnt, b_rd_cnt;
    logic [15:0] b_last_rd;
    logic [7:0]  b_last_wd;

    // Observe both bus ports mid-cycle.
    always @(negedge clk) begin
        if (!ifa.cpu_rdy) a_rdy_low++;
        if (ifa.dma_done) a_done_cnt++;
        if (ifa.dma_busy && ifa.mem_wen && ifa.mem_addr == 16'h2004) begin
            if (a_wr_cnt < 256) a_log[a_wr_cnt] = ifa.mem_wdata;
            a_wr_cnt++;
        end
        if (ifa.dma_busy && !ifa.mem_wen && ifa.mem_addr != ifa.cpu_addr) begin
            a_rd_cnt++;
            if (ifa.mem_addr[15:8] != a_page) a_bad_rd++;
            if (since_rst % 2 == 1) a_rd_odd++;
        end
        if (!ifb.cpu_rdy) b_rdy_low++;
        if (ifb.dma_done) b_done_cnt++;
        if (ifb.dma_busy && ifb.mem_wen && ifb.mem_addr == 16'h2004) begin
            b_last_wd = ifb.mem_wdata;
            b_wr_cnt++;
        end
        if (ifb.dma_busy && !ifb.mem_wen && ifb.mem_addr != ifb.cpu_addr) begin
            b_last_rd = ifb.mem_addr;
            b_rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        since_rst++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        since_rst = 0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clr_a(input logic [7:0] page);
        a_rdy_low = 0; a_done_cnt = 0; a_wr_cnt = 0;
        a_rd_cnt = 0; a_bad_rd = 0; a_rd_odd = 0;
        a_page = page;
    endtask

    task automatic clr_b();
        b_rdy_low = 0; b_done_cnt = 0; b_wr_cnt = 0; b_rd_cnt = 0;
        b_last_rd = 16'h0000; b_last_wd = 8'h00;
    endtask

    // Trigger sampled on an odd edge gives parity 1 in HALT.
    task automatic trig_a(input logic [7:0] page, input bit halt_par1);
        while ((since_rst % 2) != (halt_par1 ? 0 : 1)) tick();
        ifa.cpu_addr = 16'h4014; ifa.cpu_wdata = page; ifa.cpu_wen = 1'b1;
        tick();
        ifa.cpu_wen = 1'b0;
    endtask

    task automatic trig_b(input logic [7:0] page, input bit halt_par1);
        while ((since_rst % 2) != (halt_par1 ? 0 : 1)) tick();
        ifb.cpu_addr = 16'h4014; ifb.cpu_wdata = page; ifb.cpu_wen = 1'b1;
        tick();
        ifb.cpu_wen = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!ifa.dma_done && n < 2000) begin tick(); n++; end
        chk(tag, 32'(ifa.dma_done), 32'd1);
        tick();
    endtask

    task automatic wait_done_b(input string tag);
        int n;
        n = 0;
        while (!ifb.dma_done && n < 50) begin tick(); n++; end
        chk(tag, 32'(ifb.dma_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.cpu_addr = 16'h0000; ifa.cpu_wen = 1'b0; ifa.cpu_wdata = 8'h00;
        ifb.cpu_addr = 16'h4014; ifb.cpu_wen = 1'b0; ifb.cpu_wdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        mem[16'hFF00] = 8'h3C;
        clr_a(8'h02);
        clr_b();
        do_reset();

        // Reset state and CPU pass-through.
        chk("rst_done", 32'(ifa.dma_done), 32'd0);
        ifa.cpu_addr = 16'h1234; ifa.cpu_wen = 1'b1; ifa.cpu_wdata = 8'h5A;
        #1;
        chk("pt_addr", 32'(ifa.mem_addr), 32'h1234);
        chk("pt_wen", 32'(ifa.mem_wen), 32'd1);
        chk("pt_wdata", 32'(ifa.mem_wdata), 32'h5A);
        chk("pt_rdy", 32'(ifa.cpu_rdy), 32'd1);
        chk("pt_busy", 32'(ifa.dma_busy), 32'd0);
        tick();
        ifa.cpu_wen = 1'b0; ifa.cpu_addr = 16'h4014;
        tick();
        chk("pt_no_trig", 32'(ifa.dma_busy), 32'd0);

        // Single-byte transfer from page FF, then retrigger on the done cycle.
        clr_b();
        trig_b(8'hFF, 1'b1);
        wait_done_b("b1_done_seen");
        tick();
        chk("b1_rd_cnt", 32'(b_rd_cnt), 32'd1);
        chk("b1_rd_addr", 32'(b_last_rd), 32'hFF00);
        chk("b1_wr_cnt", 32'(b_wr_cnt), 32'd1);
        chk("b1_wr_data", 32'(b_last_wd), 32'h3C);
        chk("b1_rdy_low", 32'(b_rdy_low), 32'd3);
        chk("b1_done_cnt", 32'(b_done_cnt), 32'd1);
        clr_b();
        trig_b(8'hFF, 1'b0);
        wait_done_b("b2_done_seen");
        ifb.cpu_wen = 1'b1; ifb.cpu_wdata = 8'hFF;
        tick();
        ifb.cpu_wen = 1'b0;
        chk("b2_retrig_busy", 32'(ifb.dma_busy), 32'd1);
        wait_done_b("b3_done_seen");
        tick();
        chk("b2_rdy_low", 32'(b_rdy_low), 32'd7);
        chk("b2_done_cnt", 32'(b_done_cnt), 32'd2);
        chk("b2_wr_cnt", 32'(b_wr_cnt), 32'd2);

        // Full page, parity 1 in HALT: no ALIGN.
        clr_a(8'h02);
        trig_a(8'h02, 1'b1);
        chk("a1_busy", 32'(ifa.dma_busy), 32'd1);
        chk("a1_rdy", 32'(ifa.cpu_rdy), 32'd0);
        wait_done_a("a1_done_seen");
        chk("a1_done_pulse", 32'(ifa.dma_done), 32'd0);
        chk("a1_rdy_low", 32'(a_rdy_low), 32'd513);
        chk("a1_wr_cnt", 32'(a_wr_cnt), 32'd256);
        chk("a1_rd_cnt", 32'(a_rd_cnt), 32'd256);
        chk("a1_done_cnt", 32'(a_done_cnt), 32'd1);
        chk("a1_rd_odd", 32'(a_rd_odd), 32'd0);
        chk("a1_bad_rd", 32'(a_bad_rd), 32'd0);
        for (int i = 0; i < 256; i++) chk($sformatf("a1_data%0d", i), 32'(a_log[i]), 32'(8'(i) ^ 8'hA5));

        // Full page, parity 0 in HALT: one ALIGN cycle.
        clr_a(8'h02);
        trig_a(8'h02, 1'b0);
        wait_done_a("a2_done_seen");
        chk("a2_rdy_low", 32'(a_rdy_low), 32'd514);
        chk("a2_wr_cnt", 32'(a_wr_cnt), 32'd256);
        chk("a2_rd_odd", 32'(a_rd_odd), 32'd0);
        chk("a2_done_cnt", 32'(a_done_cnt), 32'd1);
        chk("a2_first", 32'(a_log[0]), 32'hA5);
        chk("a2_last", 32'(a_log[255]), 32'h5A);

        // Trigger of page 03 while busy is ignored.
        clr_a(8'h02);
        trig_a(8'h02, 1'b1);
        repeat (20) tick();
        ifa.cpu_wdata = 8'h03; ifa.cpu_wen = 1'b1;
        tick();
        ifa.cpu_wen = 1'b0;
        wait_done_a("a3_done_seen");
        chk("a3_bad_rd", 32'(a_bad_rd), 32'd0);
        chk("a3_rd_cnt", 32'(a_rd_cnt), 32'd256);
        chk("a3_wr_cnt", 32'(a_wr_cnt), 32'd256);
        chk("a3_rdy_low", 32'(a_rdy_low), 32'd513);
        chk("a3_last", 32'(a_log[255]), 32'h5A);

        // Reset after the 10th write aborts the transfer.
        clr_a(8'h02);
        trig_a(8'h02, 1'b1);
        begin
            int n;
            n = 0;
            while (a_wr_cnt < 10 && n < 100) begin tick(); n++; end
        end
        chk("a4_reached10", 32'(a_wr_cnt), 32'd10);
        do_reset();
        chk("a4_busy", 32'(ifa.dma_busy), 32'd0);
        chk("a4_rdy", 32'(ifa.cpu_rdy), 32'd1);
        chk("a4_done", 32'(ifa.dma_done), 32'd0);
        repeat (10) tick();
        chk("a4_wr_cnt", 32'(a_wr_cnt), 32'd10);
        chk("a4_done_cnt", 32'(a_done_cnt), 32'd0);
        chk("a4_busy_late", 32'(ifa.dma_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
